dmem_port_ctrl: RTL and testbench

Requester-side controller for the 256x32 data block RAM: accepts RV32I load/store requests from the CPU memory stage over a valid/ready handshake and drives the RAM's read and write ports. Responsibilities:
- Translates byte addresses and funct3 into word address, write mask and lane-shifted write data.
- Captures the synchronous read data and returns sign/zero-extended load results.
- Sits between the CPU pipeline and the 256x32 RAM wrapper, one instance per data memory.

---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/dmem_load_align.sv | 27 ++
 rtl/dmem_ram.sv | 32 +++
 rtl/dmem_port_ctrl.sv | 125 ++++++++++++
 tb/tb_dmem_port_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port controller.
// RV32I width codes, controller states and RAM lane masks.
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RESP
    } state_t;

    // RAM mask polarity: a 1 bit is NOT written.
    localparam logic [31:0] MASK_NONE    = 32'h0000_0000;
    localparam logic [31:0] MASK_ALL     = 32'hFFFF_FFFF;
    localparam logic [31:0] MASK_BYTE    = 32'h0000_00FF;
    localparam logic [31:0] MASK_HALF_LO = 32'h0000_FFFF;
    localparam logic [31:0] MASK_HALF_HI = 32'hFFFF_0000;

    function automatic logic access_err(
        input logic       we,
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic bad_f3;
        logic misal;
        bad_f3 = (f3[1:0] == 2'b11) || (f3[2] && f3[1]) || (we && f3[2]);
        case (f3[1:0])
            2'b01:   misal = lo[0];
            2'b10:   misal = (lo != 2'b00);
            default: misal = 1'b0;
        endcase
        return bad_f3 || misal;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load formatter: picks the addressed byte/halfword out of a RAM word
// and sign- or zero-extends it according to funct3.
module dmem_load_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    import dmem_pkg::*;

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = 8'(rdata >> {lane, 3'b000});
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{b[7]}}, b};
            F3_LH:   data = {{16{h[15]}}, h};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'h0, b};
            F3_LHU:  data = {16'h0, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ram.sv
// 256x32 synchronous block RAM wrapper with separate read/write ports
// and a per-bit inverted write mask.
module dmem_ram #(
    parameter int AW = 8
) (
    input  logic          rclk,
    input  logic          rclke,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          wclk,
    input  logic          wclke,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   mask,
    input  logic [31:0]   wdata
);
    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge wclk) begin
        if (wclke && we) begin
            mem[waddr] <= (mem[waddr] & mask) | (wdata & ~mask);
        end
    end

    always_ff @(posedge rclk) begin
        if (rclke && re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_port_ctrl.sv
// CPU-side controller for the data block RAM: accepts RV32I loads and
// stores over valid/ready and drives the RAM read/write ports.
module dmem_port_ctrl #(
    parameter int WORD_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [WORD_AW+1:0] req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    output logic [WORD_AW-1:0] ram_raddr,
    output logic [WORD_AW-1:0] ram_waddr,
    output logic               ram_re,
    output logic               ram_rclke,
    output logic               ram_we,
    output logic               ram_wclke,
    output logic [31:0]        ram_mask,
    output logic [31:0]        ram_wdata,
    input  logic [31:0]        ram_rdata
);
    import dmem_pkg::*;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [1:0]  lane;
    logic        err;
    logic        accept;
    logic [31:0] load_data;

    assign lane      = req_addr[1:0];
    assign req_ready = (state == IDLE);
    assign err       = access_err(req_we, req_funct3, lane);
    assign accept    = req_valid && req_ready && !reset;

    // RAM sees the request on the same edge that accepts it.
    assign ram_re    = accept && !req_we && !err;
    assign ram_rclke = ram_re;
    assign ram_we    = accept && req_we && !err;
    assign ram_wclke = ram_we;
    assign ram_raddr = req_addr[WORD_AW+1:2];
    assign ram_waddr = req_addr[WORD_AW+1:2];

    always_comb begin
        ram_mask  = MASK_ALL;
        ram_wdata = req_wdata;
        case (req_funct3)
            F3_SB: begin
                ram_mask  = ~(MASK_BYTE << {lane, 3'b000});
                ram_wdata = {4{req_wdata[7:0]}};
            end
            F3_SH: begin
                ram_mask  = lane[1] ? MASK_HALF_LO : MASK_HALF_HI;
                ram_wdata = {2{req_wdata[15:0]}};
            end
            F3_SW: begin
                ram_mask  = MASK_NONE;
            end
            default: begin
                ram_mask  = MASK_ALL;
            end
        endcase
    end

    dmem_load_align u_align (
        .funct3 (f3_q),
        .lane   (lane_q),
        .rdata  (ram_rdata),
        .data   (load_data)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (req_we || err) ? RESP : LOAD;
                end
            end
            LOAD: state_nx = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            f3_q       <= '0;
            lane_q     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                f3_q       <= req_funct3;
                lane_q     <= lane;
                resp_err   <= err;
                resp_rdata <= '0;
                resp_valid <= req_we || err;
            end else if (state == LOAD) begin
                resp_rdata <= load_data;
                resp_valid <= 1'b1;
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Self-checking bench: controller plus RAM against a byte-array model,
// directed test-plan steps followed by randomized traffic.
module tb_dmem_port_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  ram_raddr;
    logic [7:0]  ram_waddr;
    logic        ram_re;
    logic        ram_rclke;
    logic        ram_we;
    logic        ram_wclke;
    logic [31:0] ram_mask;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    dmem_port_ctrl #(.WORD_AW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_raddr  (ram_raddr),
        .ram_waddr  (ram_waddr),
        .ram_re     (ram_re),
        .ram_rclke  (ram_rclke),
        .ram_we     (ram_we),
        .ram_wclke  (ram_wclke),
        .ram_mask   (ram_mask),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    dmem_ram #(.AW(8)) u_ram (
        .rclk  (clk),
        .rclke (ram_rclke),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata),
        .wclk  (clk),
        .wclke (ram_wclke),
        .we    (ram_we),
        .waddr (ram_waddr),
        .mask  (ram_mask),
        .wdata (ram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mb [0:1023];
    logic [31:0] got_rdata;
    logic [31:0] got_mask;
    logic [31:0] got_wdata;
    logic        got_err;
    logic        got_re;
    logic        got_we;
    int          got_lat;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3,
                                       input logic [9:0] addr);
        logic legal;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return !legal || ((int'(addr) % size_of(f3)) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3,
                                               input logic [9:0] addr);
        int          sz;
        logic [31:0] v;
        sz = size_of(f3);
        v = 0;
        for (int i = 0; i < sz; i++) v = v | (32'(mb[int'(addr) + i]) << (8 * i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 1);
        return v;
    endfunction

    task automatic xfer(input logic we, input logic [2:0] f3,
                        input logic [9:0] addr, input logic [31:0] wd,
                        input int hold);
        logic [31:0] held;
        logic        seen;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        #1;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        check("rclke_eq_re", 32'(ram_rclke), 32'(ram_re));
        check("wclke_eq_we", 32'(ram_wclke), 32'(ram_we));
        got_re    = ram_re;
        got_we    = ram_we;
        got_mask  = ram_mask;
        got_wdata = ram_wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seen = 1'b0;
        got_lat = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            got_lat = c;
            seen = resp_valid;
        end
        if (!seen) begin
            check("resp_timeout", 32'(resp_valid), 32'd1);
            got_lat = 99;
        end
        got_rdata = resp_rdata;
        got_err   = resp_err;
        held      = resp_rdata;
        for (int h = 0; h < hold; h++) begin
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_funct3 = 3'd2;
            req_addr   = 10'h000;
            #1;
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_ram_re", 32'(ram_re), 32'd0);
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_rdata", resp_rdata, held);
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("post_hs_valid", 32'(resp_valid), 32'd0);
        check("post_hs_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic run(input logic we, input logic [2:0] f3,
                       input logic [9:0] addr, input logic [31:0] wd,
                       input int hold);
        logic        e;
        int          sz;
        int          lo;
        logic [31:0] em;
        logic [31:0] ew;
        e  = model_err(we, f3, addr);
        sz = size_of(f3);
        lo = int'(addr) % 4;
        xfer(we, f3, addr, wd, hold);
        check("resp_err", 32'(got_err), 32'(e));
        check("resp_rdata", got_rdata, (we || e) ? 32'd0 : model_load(f3, addr));
        check("latency", 32'(got_lat), (!we && !e) ? 32'd2 : 32'd1);
        check("ram_re", 32'(got_re), 32'(!we && !e));
        check("ram_we", 32'(got_we), 32'(we && !e));
        if (we && !e) begin
            em = 32'hFFFF_FFFF;
            for (int l = 0; l < 4; l++) begin
                if (l >= lo && l < lo + sz) em[8*l +: 8] = 8'h00;
                ew[8*l +: 8] = wd[8*(l % sz) +: 8];
            end
            check("ram_mask", got_mask, em);
            check("ram_wdata", got_wdata, ew);
            for (int i = 0; i < sz; i++) mb[int'(addr) + i] = wd[8*i +: 8];
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_funct3 = 3'd2;
        #1;
        check("rst_ram_we", 32'(ram_we), 32'd0);
        req_valid = 1'b0;
        reset = 1'b0;

        for (int w = 0; w < 64; w++) run(1'b1, 3'd2, 10'(w * 4), $urandom, 0);

        run(1'b1, 3'd2, 10'h010, 32'hDEAD_BEEF, 0);
        check("sw_mask_zero", got_mask, 32'h0000_0000);
        run(1'b0, 3'd2, 10'h010, 32'h0, 0);
        check("lw_deadbeef", got_rdata, 32'hDEAD_BEEF);

        run(1'b1, 3'd0, 10'h013, 32'h0000_0080, 0);
        run(1'b0, 3'd0, 10'h013, 32'h0, 0);
        check("lb_sext", got_rdata, 32'hFFFF_FF80);
        run(1'b0, 3'd4, 10'h013, 32'h0, 0);
        check("lbu_zext", got_rdata, 32'h0000_0080);
        run(1'b0, 3'd2, 10'h010, 32'h0, 0);
        check("sb_neighbors", got_rdata, 32'h80AD_BEEF);

        run(1'b1, 3'd2, 10'h020, 32'h0, 0);
        run(1'b1, 3'd1, 10'h022, 32'h0000_1234, 0);
        check("sh_mask", got_mask, 32'h0000_FFFF);
        run(1'b0, 3'd2, 10'h020, 32'h0, 0);
        check("sh_word", got_rdata, 32'h1234_0000);

        run(1'b0, 3'd1, 10'h001, 32'h0, 0);
        check("lh_mis_err", 32'(got_err), 32'd1);
        check("lh_mis_re", 32'(got_re), 32'd0);
        run(1'b1, 3'd2, 10'h002, 32'hFFFF_FFFF, 0);
        check("sw_mis_err", 32'(got_err), 32'd1);
        run(1'b0, 3'd2, 10'h000, 32'h0, 0);

        run(1'b0, 3'd2, 10'h010, 32'h0, 5);
        check("bp_load_data", got_rdata, 32'h80AD_BEEF);

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 10'h010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b1;
        #1;
        check("rstld_valid", 32'(resp_valid), 32'd0);
        check("rstld_ready", 32'(req_ready), 32'd1);
        check("rstld_ram_re", 32'(ram_re), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rstld_no_resp", 32'(resp_valid), 32'd0);
            check("rstld_idle", 32'(req_ready), 32'd1);
        end
        run(1'b0, 3'd2, 10'h010, 32'h0, 0);
        check("rstld_word", got_rdata, 32'h80AD_BEEF);

        for (int k = 0; k < 200; k++) begin
            run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                10'($urandom_range(0, 255)), $urandom,
                int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
